// File: rtl/ndn_link_pkg.sv
// ndn_link_pkg: shared types and constants for the NDN bit-serial link.
//   - tx_state_e / rx_state_e : transmitter and receiver FSM encodings
//   - META_TYPE_BIT           : meta bit that carries the packet type
//   - INTEREST                : value of the type bit for interest packets
//   - START_BIT / END_BIT     : line levels of the frame delimiters
//   - IDLE_LEVEL              : level of an idle serial line
package ndn_link_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD_META,
    TX_LOAD_PREFIX,
    TX_LOAD_DATA,
    TX_START,
    TX_SEND,
    TX_PARITY,
    TX_END
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_META,
    RX_PREFIX,
    RX_DATA,
    RX_PARITY,
    RX_END
  } rx_state_e;

  localparam int   META_TYPE_BIT = 6;
  localparam logic INTEREST      = 1'b1;
  localparam logic START_BIT     = 1'b0;
  localparam logic END_BIT       = 1'b0;
  localparam logic IDLE_LEVEL    = 1'b1;

endpackage

// File: rtl/ndn_link_rx.sv
// ndn_link_rx: deserialiser for the NDN bit-serial link.
// Samples miso once per clk, recognises a start bit, shifts meta, prefix and
// (for data packets) data MSB first, then checks the end bit.
// Optional build macro NDN_LINK_PARITY_EN: an even-parity bit over all payload
// bits precedes the end bit; a mismatch is reported as a framing error.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   miso       : serial input, idles high
//   rx_valid   : one-cycle pulse, rx_* hold a complete packet
//   rx_error   : one-cycle pulse on a bad end bit (or parity)
//   rx_meta    : received meta byte
//   rx_prefix  : received prefix, first byte in the top bits
//   rx_data    : received data, zero for interest packets
module ndn_link_rx
  import ndn_link_pkg::*;
#(
  parameter int PREFIX_BYTES = 8,
  parameter int DATA_BYTES   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      miso,
  output logic                      rx_valid,
  output logic                      rx_error,
  output logic [7:0]                rx_meta,
  output logic [PREFIX_BYTES*8-1:0] rx_prefix,
  output logic [DATA_BYTES*8-1:0]   rx_data
);

  localparam int PREFIX_BITS = PREFIX_BYTES * 8;
  localparam int DATA_BITS   = DATA_BYTES * 8;
  localparam int MAX_BITS    = (PREFIX_BITS > DATA_BITS) ? PREFIX_BITS : DATA_BITS;
  localparam int CNT_W       = $clog2(MAX_BITS);

  localparam logic [CNT_W-1:0] META_LAST   = CNT_W'(7);
  localparam logic [CNT_W-1:0] PREFIX_LAST = CNT_W'(PREFIX_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST   = CNT_W'(DATA_BITS - 1);

`ifdef NDN_LINK_PARITY_EN
  localparam rx_state_e AFTER_PAYLOAD = RX_PARITY;
`else
  localparam rx_state_e AFTER_PAYLOAD = RX_END;
`endif

  rx_state_e                state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     armed_q, armed_d;
  logic                     is_int_q, is_int_d;
  logic [7:0]               meta_q, meta_d;
  logic [PREFIX_BITS-1:0]   prefix_q, prefix_d;
  logic [DATA_BITS-1:0]     data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     error_q, error_d;
  logic                     frame_ok;
`ifdef NDN_LINK_PARITY_EN
  logic                     par_q, par_d;
  logic                     perr_q, perr_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    is_int_d = is_int_q;
    meta_d   = meta_q;
    prefix_d = prefix_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
`ifdef NDN_LINK_PARITY_EN
    par_d    = par_q;
    perr_d   = perr_q;
    frame_ok = (miso == END_BIT) && !perr_q;
`else
    frame_ok = (miso == END_BIT);
`endif
    case (state_q)
      RX_IDLE: begin
        // Only a high-to-low transition starts a frame, so a line stuck low
        // after a frame (or after reset) cannot retrigger the receiver.
        if (armed_q && (miso == START_BIT)) begin
          state_d  = RX_META;
          cnt_d    = '0;
          armed_d  = 1'b0;
          meta_d   = '0;
          prefix_d = '0;
          data_d   = '0;
`ifdef NDN_LINK_PARITY_EN
          par_d    = 1'b0;
          perr_d   = 1'b0;
`endif
        end else begin
          armed_d = armed_q | (miso == IDLE_LEVEL);
        end
      end
      RX_META: begin
        meta_d = {meta_q[6:0], miso};
        cnt_d  = cnt_q + CNT_W'(1);
`ifdef NDN_LINK_PARITY_EN
        par_d  = par_q ^ miso;
`endif
        if (cnt_q == META_LAST) begin
          cnt_d    = '0;
          is_int_d = (meta_d[META_TYPE_BIT] == INTEREST);
          state_d  = RX_PREFIX;
        end
      end
      RX_PREFIX: begin
        prefix_d = {prefix_q[PREFIX_BITS-2:0], miso};
        cnt_d    = cnt_q + CNT_W'(1);
`ifdef NDN_LINK_PARITY_EN
        par_d    = par_q ^ miso;
`endif
        if (cnt_q == PREFIX_LAST) begin
          cnt_d   = '0;
          state_d = is_int_q ? AFTER_PAYLOAD : RX_DATA;
        end
      end
      RX_DATA: begin
        data_d = {data_q[DATA_BITS-2:0], miso};
        cnt_d  = cnt_q + CNT_W'(1);
`ifdef NDN_LINK_PARITY_EN
        par_d  = par_q ^ miso;
`endif
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = AFTER_PAYLOAD;
        end
      end
`ifdef NDN_LINK_PARITY_EN
      RX_PARITY: begin
        perr_d  = (miso != par_q);
        state_d = RX_END;
      end
`endif
      RX_END: begin
        valid_d = frame_ok;
        error_d = !frame_ok;
        state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      is_int_q <= 1'b0;
      meta_q   <= '0;
      prefix_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
`ifdef NDN_LINK_PARITY_EN
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      is_int_q <= is_int_d;
      meta_q   <= meta_d;
      prefix_q <= prefix_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
`ifdef NDN_LINK_PARITY_EN
      par_q    <= par_d;
      perr_q   <= perr_d;
`endif
    end
  end

  assign rx_valid  = valid_q;
  assign rx_error  = error_q;
  assign rx_meta   = meta_q;
  assign rx_prefix = prefix_q;
  assign rx_data   = data_q;

endmodule

// File: rtl/ndn_serial_link.sv
// ndn_serial_link: full-duplex bit-serial NDN packet link.
// TX: bytes are loaded over a valid/ready handshake (meta, prefix, then data
// for data packets) into a byte buffer, then framed onto mosi one bit per clk
// with cs low for the whole frame. RX: handled by ndn_link_rx.
// Optional build macro NDN_LINK_PARITY_EN: an even-parity bit over all payload
// bits is sent between the last payload bit and the end bit.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   sclk                : serial clock (copy of clk)
//   cs                  : low while a TX frame is on mosi
//   mosi / miso         : serial TX / RX lines, idle high
//   tx_byte/valid/ready : byte load handshake
//   tx_busy             : first accepted byte until the end bit has been sent
//   rx_valid, rx_error  : one-cycle receive status pulses
//   rx_meta/prefix/data : received packet fields
module ndn_serial_link
  import ndn_link_pkg::*;
#(
  parameter int PREFIX_BYTES = 8,
  parameter int DATA_BYTES   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      sclk,
  output logic                      cs,
  output logic                      mosi,
  input  logic                      miso,
  input  logic [7:0]                tx_byte,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      tx_busy,
  output logic                      rx_valid,
  output logic                      rx_error,
  output logic [7:0]                rx_meta,
  output logic [PREFIX_BYTES*8-1:0] rx_prefix,
  output logic [DATA_BYTES*8-1:0]   rx_data
);

  localparam int TOTAL_BYTES = 1 + PREFIX_BYTES + DATA_BYTES;
  localparam int IDX_W       = $clog2(TOTAL_BYTES);
  localparam int MEM_DEPTH   = 2 ** IDX_W;

  localparam logic [IDX_W-1:0] PREFIX_LAST_IDX = IDX_W'(PREFIX_BYTES);
  localparam logic [IDX_W-1:0] DATA_LAST_IDX   = IDX_W'(TOTAL_BYTES - 1);

`ifdef NDN_LINK_PARITY_EN
  localparam tx_state_e AFTER_PAYLOAD = TX_PARITY;
`else
  localparam tx_state_e AFTER_PAYLOAD = TX_END;
`endif

  tx_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       bit_q, bit_d;
  logic             is_int_q, is_int_d;
  logic [IDX_W-1:0] rd_addr;
  logic [IDX_W-1:0] last_idx;
  logic [7:0]       rd_data_q;
  logic             accept;
  logic             tx_bit;
`ifdef NDN_LINK_PARITY_EN
  logic             par_q, par_d;
`endif

  // Packet buffer: byte 0 is meta, then prefix, then data.
  logic [7:0] buf_mem [MEM_DEPTH];

  assign tx_ready = (state_q == TX_LOAD_META) || (state_q == TX_LOAD_PREFIX) ||
                    (state_q == TX_LOAD_DATA);
  assign accept   = tx_valid && tx_ready;
  assign last_idx = is_int_q ? PREFIX_LAST_IDX : DATA_LAST_IDX;
  // Bits leave MSB first from the byte read out of the buffer.
  assign tx_bit   = rd_data_q[~bit_q];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    bit_d    = bit_q;
    is_int_d = is_int_q;
    rd_addr  = idx_q;
`ifdef NDN_LINK_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      TX_IDLE: begin
        idx_d   = '0;
        state_d = TX_LOAD_META;
      end
      TX_LOAD_META: begin
        if (accept) begin
          is_int_d = (tx_byte[META_TYPE_BIT] == INTEREST);
          idx_d    = IDX_W'(1);
          state_d  = TX_LOAD_PREFIX;
        end
      end
      TX_LOAD_PREFIX: begin
        if (accept) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == PREFIX_LAST_IDX) begin
            state_d = is_int_q ? TX_START : TX_LOAD_DATA;
          end
        end
      end
      TX_LOAD_DATA: begin
        if (accept) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == DATA_LAST_IDX) begin
            state_d = TX_START;
          end
        end
      end
      TX_START: begin
        // The buffer read is registered, so byte 0 is fetched here to be
        // ready in the first SEND cycle.
        rd_addr = '0;
        idx_d   = '0;
        bit_d   = '0;
`ifdef NDN_LINK_PARITY_EN
        par_d   = 1'b0;
`endif
        state_d = TX_SEND;
      end
      TX_SEND: begin
        bit_d = bit_q + 3'd1;
`ifdef NDN_LINK_PARITY_EN
        par_d = par_q ^ tx_bit;
`endif
        if (bit_q == 3'd7) begin
          // Prefetch the next byte on the last bit of the current one.
          rd_addr = idx_q + IDX_W'(1);
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == last_idx) begin
            state_d = AFTER_PAYLOAD;
          end
        end
      end
      TX_PARITY: state_d = TX_END;
      TX_END:    state_d = TX_IDLE;
      default:   state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_mem[idx_q] <= tx_byte;
    end
    rd_data_q <= buf_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= TX_IDLE;
      idx_q    <= '0;
      bit_q    <= '0;
      is_int_q <= 1'b0;
`ifdef NDN_LINK_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      bit_q    <= bit_d;
      is_int_q <= is_int_d;
`ifdef NDN_LINK_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // Line outputs are decoded from registered state only.
  always_comb begin
    mosi = IDLE_LEVEL;
    case (state_q)
      TX_START: mosi = START_BIT;
      TX_SEND:  mosi = tx_bit;
`ifdef NDN_LINK_PARITY_EN
      TX_PARITY: mosi = par_q;
`endif
      TX_END:   mosi = END_BIT;
      default:  mosi = IDLE_LEVEL;
    endcase
  end

  assign cs      = !((state_q == TX_START) || (state_q == TX_SEND) ||
                     (state_q == TX_PARITY) || (state_q == TX_END));
  assign tx_busy = !((state_q == TX_IDLE) || (state_q == TX_LOAD_META));
  assign sclk    = clk;

  ndn_link_rx #(
    .PREFIX_BYTES(PREFIX_BYTES),
    .DATA_BYTES  (DATA_BYTES)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .miso     (miso),
    .rx_valid (rx_valid),
    .rx_error (rx_error),
    .rx_meta  (rx_meta),
    .rx_prefix(rx_prefix),
    .rx_data  (rx_data)
  );

endmodule

// File: doc/ndn_serial_link.md
Name: ndn_serial_link

Overview:
Parametrised full-duplex bit-serial packet link between the NDN core and an outgoing interface.
- TX side accepts a packet one byte per handshake, buffers it, then serialises it on mosi.
- RX side deserialises frames from miso into parallel meta/prefix/data registers.
- Generalises the fixed 8-byte-prefix link: configurable prefix/data sizes, valid/ready byte loading, active chip select, framing-error detection.

Parameters:
PREFIX_BYTES, 8, prefix length in bytes (1..32)
DATA_BYTES, 32, data-packet payload length in bytes (1..64)

Ports:
clk  in  1  system clock; serial bit rate = one bit per clk
rst  in  1  synchronous active-high reset
sclk  out  1  serial clock, driven as clk
cs  out  1  chip select, low while a TX frame is on mosi, else high
mosi  out  1  serial TX line, idles high
miso  in  1  serial RX line, idles high
tx_byte  in  8  TX byte: meta first, then prefix MSB-byte first, then data
tx_valid  in  1  tx_byte valid
tx_ready  out  1  block accepts tx_byte this cycle
tx_busy  out  1  high from first accepted byte until the end bit has been sent
rx_valid  out  1  one-cycle pulse; rx_* registers hold a complete packet
rx_error  out  1  one-cycle pulse on framing error
rx_meta  out  8  received meta byte
rx_prefix  out  PREFIX_BYTES*8  received prefix
rx_data  out  DATA_BYTES*8  received data, zero for interest packets

Behaviour:
- Meta byte layout: bit7 = don't-care; bit6 = type (1 = interest, 0 = data); bits5:0 = prefix length, passed through unchecked.
- Frame format: start bit 0; meta, prefix, then data (data packets only), all MSB first; end bit 0; line then returns high.
- Reset state: mosi=1, cs=1, tx_ready=0, tx_busy=0, rx_valid=0, rx_error=0, all rx_* registers zero, both FSMs in IDLE. Reset mid-frame aborts both directions immediately.
- TX FSM:
  - IDLE -> LOAD_META: tx_ready=1. The byte is accepted on any cycle with tx_valid && tx_ready.
  - LOAD_META -> LOAD_PREFIX: after 1 accept; bit6 is latched.
  - LOAD_PREFIX -> LOAD_DATA (data packet) or START (interest): after PREFIX_BYTES accepts.
  - LOAD_DATA -> START: after DATA_BYTES accepts.
  - START: mosi=0, cs=0, tx_ready=0, for 1 cycle.
  - SEND: 8*(1+PREFIX_BYTES[+DATA_BYTES]) cycles, one bit per cycle.
  - END: mosi=0 for 1 cycle. Next cycle: mosi=1, cs=1, tx_busy=0; FSM returns to IDLE/LOAD_META.
  - tx_valid low during a load stalls loading with no timeout. Bytes offered while tx_ready=0 are ignored.
- RX FSM:
  - IDLE: a miso=0 sample is taken as the start bit. At this point rx_meta, rx_prefix and rx_data are cleared.
  - META: 8 bits; bit6 selects the path.
  - PREFIX: PREFIX_BYTES*8 bits.
  - DATA: DATA_BYTES*8 bits, data packets only.
  - END: samples the end bit. 0 -> rx_valid=1 on the next cycle. 1 -> rx_error=1 on the next cycle and registers are left as received.
  - FSM returns to IDLE the cycle after END. It waits for miso=1 before accepting a new start bit, so an idle-low line does not retrigger.
- Latency: the last payload bit is sampled at cycle N; END is at N+1; rx_valid is at N+2.
- TX and RX operate independently and simultaneously.
- Bit counters sized by $clog2 of the largest field; no wrap-around occurs within a frame.

Optional Feature:
NDN_LINK_PARITY_EN.
- Defined: one even-parity bit (XOR over all payload bits) is inserted between the last payload bit and the end bit, on both TX and RX. A parity mismatch gives rx_error=1 instead of rx_valid, at the same cycle position.
- Undefined: no parity bit; frame length is exactly as above.

Decomposition:
- Package ndn_link_pkg holds: TX/RX state enums, META_TYPE_BIT=6, INTEREST=1'b1, START_BIT=1'b0, END_BIT=1'b0, IDLE_LEVEL=1'b1.
- Sub-module ndn_link_rx holds the deserialiser FSM; the top level holds the TX FSM and instantiates ndn_link_rx.

Test Plan:
- Loopback (miso=mosi), interest, PREFIX_BYTES=8, meta 0x48, prefix 0x0123456789ABCDEF -> rx_valid once; rx_meta=0x48; rx_prefix matches; rx_data=0; cs low for exactly 74 cycles.
- Loopback, data packet, meta 0x08, prefix all 0xA5, data bytes 0x00..0x1F -> rx_data[255:248]=0x00 and rx_data[7:0]=0x1F; tx_busy deasserts at the cycle after the end bit.
- tx_valid toggled every other cycle during load -> only cycles with tx_valid && tx_ready are accepted; frame is identical to the contiguous-load frame.
- Drive an interest frame with end bit 1 -> rx_error pulse; no rx_valid; next good frame is received correctly.
- Assert rst at bit 20 of a TX frame -> next cycle mosi=1, cs=1, tx_busy=0; a following packet is sent intact.
- With NDN_LINK_PARITY_EN defined, flip one prefix bit in the driven frame -> rx_error=1, rx_valid=0; an unflipped frame -> rx_valid=1.
